hazard_ctrl: RTL
================

# hazard_ctrl

Central pipeline controller for the rv32i 5-stage core. It generates every stall, flush and bubble signal for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and resolves load-use hazards, taken branches/jumps, multi-cycle data-memory waits and FENCE.I drains. It sits beside the datapath, watches decoded register fields and stage status, and drives the pipeline-register control pins. It also keeps saturating stall and flush counters and a sticky memory-timeout flag for debug.

## Interface

**Parameters**
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before `mem_timeout` sets. Range 1..65535.
- `CNT_W`, default 32: width of the performance counters.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction reads rs1 / rs2.
- `id_fence_i` in 1: the ID instruction is FENCE.I.
- `id_pc` in 32: PC of the ID instruction.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_redirect` in 1: the EX instruction is a taken branch or jump.
- `ex_target` in 32: redirect target.
- `dmem_req` in 1: MEM stage has an active data access.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_stall` out 1: hold the PC.
- `if_id_stall` out 1: hold IF/ID.
- `if_id_flush` out 1: load a NOP (32'h00000013) into IF/ID.
- `id_ex_flush` out 1: load a bubble into ID/EX.
- `ex_mem_stall` out 1: hold ID/EX and EX/MEM.
- `mem_wb_bubble` out 1: load a bubble into MEM/WB.
- `pc_redirect` out 1: PC loads `pc_redirect_addr`.
- `pc_redirect_addr` out 32: new PC.
- `mem_timeout` out 1: sticky timeout flag.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counters.

## Operation

**State machine:** RUN, MEM_WAIT, DRAIN. All control outputs are combinational from the current state and inputs. State, counters and `mem_timeout` are registered.

**RUN, priority high to low:**
1. **Data-memory wait** (`dmem_req && !dmem_ready`):
   - Assert `pc_stall`, `if_id_stall`, `ex_mem_stall`, `mem_wb_bubble`.
   - Go to MEM_WAIT.
   - Ignore `ex_redirect`. The EX instruction is frozen, so it is re-seen later.
2. **Redirect** (`ex_redirect`):
   - Assert `pc_redirect` with `pc_redirect_addr = ex_target`, `if_id_flush` and `id_ex_flush`.
   - Suppress any load-use stall and any FENCE.I entry.
3. **Load-use:** `ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))`.
   - Assert `pc_stall`, `if_id_stall`, `id_ex_flush`.
   - One-cycle stall per occurrence.
4. **FENCE.I** (`id_fence_i`):
   - Assert `pc_stall`, `if_id_stall`, `id_ex_flush`.
   - Load the drain counter with 3 and go to DRAIN.

**MEM_WAIT:**
- Hold all four stall/bubble outputs while `!dmem_ready`.
- On `dmem_ready`, deassert them in that same cycle and return to RUN.
- The wait counter increments each MEM_WAIT cycle. When it reaches `MEM_TIMEOUT`, set `mem_timeout`. It stays set until `rst`. The wait itself continues.

**DRAIN:**
- Each cycle assert `pc_stall`, `if_id_stall`, `id_ex_flush`, and decrement the drain counter.
- A `dmem_req && !dmem_ready` during DRAIN asserts the full freeze and pauses the drain counter. The state stays DRAIN.
- When the counter reaches 0:
  - Assert `pc_redirect` with addr `id_pc + 4` (mod 2^32), plus `if_id_flush` and `id_ex_flush`.
  - Return to RUN.

**Counters:**
- `stall_cnt` increments in any cycle with `pc_stall` high.
- `flush_cnt` increments in any cycle with `if_id_flush` high.
- Both saturate at all-ones.

**Idle output values:** when no hazard is active, all control outputs are 0 and `pc_redirect_addr = 0`.

## Timing

- **Reset:** in a cycle with `rst`, all control outputs are forced 0 and `pc_redirect_addr = 0`. On the next edge: state RUN, counters 0, `mem_timeout` 0, drain counter 0, wait counter 0.
- **Reset mid-operation:** `rst` during MEM_WAIT or DRAIN aborts to RUN with no redirect issued.
- **Latency:**
  - Hazard-to-control latency is zero cycles (combinational).
  - Counter and flag updates are visible one cycle later.
- **Load-use:** exactly one bubble.
- **FENCE.I:** 3 drain cycles plus 1 redirect cycle, with no memory stalls. Each memory-stall cycle adds one.
- **Redirect:** costs exactly 2 flushed slots.
- **Simultaneous events:** redirect together with load-use produces the redirect only. `pc_stall` is low that cycle.

## Structure

- **Shared package `rv32_pkg`:** `ctrl_state_t` enum (RUN, MEM_WAIT, DRAIN), `NOP_INSTR = 32'h00000013`, `REG_ZERO = 5'd0`.
- **Sub-module `sat_counter`:** parameter `W`; ports `clk`, `rst`, `inc`, `q`. Instantiated twice, for `stall_cnt` and `flush_cnt`.

## Test plan

1. **Load-use:** `ex_mem_read=1`, `ex_rd=5`, `id_rs1=5`, `id_use_rs1=1` → `pc_stall`, `if_id_stall`, `id_ex_flush` high for 1 cycle; `stall_cnt` becomes 1.
2. **x0 destination:** same as scenario 1 but `ex_rd=0` → no stall.
3. **Redirect vs. load-use:** `ex_redirect=1`, `ex_target=32'h0000_0100` concurrent with a load-use match → `pc_redirect=1`, addr 32'h100, both flushes high, `pc_stall` low.
4. **Memory wait:** `dmem_req=1` with `dmem_ready` low for 4 cycles, then high → full freeze for 4 cycles, released in the ready cycle; `stall_cnt` becomes 4. Separately, with `MEM_TIMEOUT=3` and a 5-cycle wait, `mem_timeout` sets and stays set.
5. **FENCE.I:** `id_fence_i=1` at `id_pc=32'hFFFF_FFFC` → 4 stall cycles (entry plus 3 drain), then `pc_redirect` to 32'h0000_0000 (wrap).
6. **Reset mid-DRAIN:** `rst` asserted on drain cycle 2 → no redirect, state RUN, counters 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared types and constants for the rv32i pipeline controller
package rv32_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } ctrl_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic [1:0]  DRAIN_LOAD = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - free-running event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count qualifying cycles, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/bubble generation for the 5-stage rv32i pipeline
module hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_fence_i,
    input  logic [31:0]      id_pc,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             pc_redirect,
    output logic [31:0]      pc_redirect_addr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [16:0] TIMEOUT_LIM = 17'(MEM_TIMEOUT);

    ctrl_state_t state, state_next;
    logic [1:0]  drain_cnt, drain_next;
    logic [15:0] wait_cnt;
    logic [16:0] wait_inc;
    logic        mem_stall_req;
    logic        load_use;

    assign mem_stall_req = dmem_req && !dmem_ready;
    assign load_use      = ex_mem_read && (ex_rd != REG_ZERO) &&
                           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                            (id_use_rs2 && (id_rs2 == ex_rd)));
    assign wait_inc      = {1'b0, wait_cnt} + 17'd1;

    // Register the controller state, drain countdown, memory-wait length and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= 2'd0;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (state == MEM_WAIT) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_inc[15:0];
                end
                if (wait_inc >= TIMEOUT_LIM) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= 16'd0;
            end
        end
    end

    // Decode hazards in priority order into next state and the pipeline control pins.
    always_comb begin
        state_next       = state;
        drain_next       = drain_cnt;
        pc_stall         = 1'b0;
        if_id_stall      = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_stall     = 1'b0;
        mem_wb_bubble    = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = 32'd0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_stall_req) begin
                        // The frozen EX instruction keeps any redirect for later.
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        ex_mem_stall  = 1'b1;
                        mem_wb_bubble = 1'b1;
                        state_next    = MEM_WAIT;
                    end else if (ex_redirect) begin
                        pc_redirect      = 1'b1;
                        pc_redirect_addr = ex_target;
                        if_id_flush      = 1'b1;
                        id_ex_flush      = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (id_fence_i) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        drain_next  = DRAIN_LOAD;
                        state_next  = DRAIN;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        ex_mem_stall  = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
                DRAIN: begin
                    if (mem_stall_req) begin
                        // Older stores are still completing; hold the drain count.
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        ex_mem_stall  = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end else if (drain_cnt == 2'd0) begin
                        // Refetch everything after the FENCE.I.
                        pc_redirect      = 1'b1;
                        pc_redirect_addr = id_pc + 32'd4;
                        if_id_flush      = 1'b1;
                        id_ex_flush      = 1'b1;
                        state_next       = RUN;
                    end else begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        drain_next  = drain_cnt - 2'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_stall),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if_id_flush),
        .q   (flush_cnt)
    );

endmodule
